// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex WIDTH-bit SPI shifter.
// It sequences one whole word per load, using sample/shift strobes from the edge detector, and
// reports the received word with a one-cycle rx_valid strobe.
// Optional feature: define SPI_SHIFT_LSB_FIRST_EN to add the lsb_first input. The input is
// latched per word and selects LSB-first shifting.
module spi_shift_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sample_strobe,
    input  logic             shift_strobe,
    input  logic             abort,
    input  logic             serial_in,
    output logic             serial_out,
    output logic             busy,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data
`ifdef SPI_SHIFT_LSB_FIRST_EN
    ,
    input  logic             lsb_first
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bitcnt;
    logic             r_sample_bit;
    logic [WIDTH-1:0] r_rx_data;
    logic             r_rx_valid;

    logic             w_lsb;
    logic             w_bit;
    logic [WIDTH-1:0] w_shreg_shifted;

`ifdef SPI_SHIFT_LSB_FIRST_EN
    logic             r_lsb_mode;
    assign w_lsb = r_lsb_mode;
`else
    assign w_lsb = 1'b0;
`endif

    // Incoming bit and next shifter value; a same-cycle sample bypasses the sample register
    always_comb begin
        w_bit           = sample_strobe ? serial_in : r_sample_bit;
        w_shreg_shifted = w_lsb ? {w_bit, r_shreg[WIDTH-1:1]} : {r_shreg[WIDTH-2:0], w_bit};
    end

    // Word sequencer: IDLE -> SHIFT -> DONE -> IDLE, abort overrides everything but reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_shreg      <= '0;
            r_bitcnt     <= '0;
            r_sample_bit <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
`ifdef SPI_SHIFT_LSB_FIRST_EN
            r_lsb_mode   <= 1'b0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            if (abort) begin
                r_state  <= StIdle;
                r_shreg  <= '0;
                r_bitcnt <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (load_valid) begin
                            r_shreg    <= load_data;
                            r_bitcnt   <= '0;
                            r_state    <= StShift;
`ifdef SPI_SHIFT_LSB_FIRST_EN
                            r_lsb_mode <= lsb_first;
`endif
                        end
                    end
                    StShift: begin
                        if (sample_strobe) begin
                            r_sample_bit <= serial_in;
                        end
                        if (shift_strobe) begin
                            r_shreg  <= w_shreg_shifted;
                            r_bitcnt <= r_bitcnt + CntOne;
                            // Capture on entry to DONE so rx_data is valid alongside rx_valid
                            if (r_bitcnt == LastCnt) begin
                                r_state    <= StDone;
                                r_rx_data  <= w_shreg_shifted;
                                r_rx_valid <= 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign serial_out = w_lsb ? r_shreg[0] : r_shreg[WIDTH-1];
    assign busy       = (r_state != StIdle);
    assign load_ready = (r_state == StIdle);
    assign rx_valid   = r_rx_valid;
    assign rx_data    = r_rx_data;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Testbench for spi_shift_engine (WIDTH=8). A word-level model tracks the loaded word, the shift
// count and the received bits. The model is compared every cycle, and literal expectations pin
// the model itself.
module tb_spi_shift_engine;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         sample_strobe;
    logic         shift_strobe;
    logic         abort;
    logic         ser_drv;
    logic         loop_en;
    logic         serial_in;
    logic         lsb_first;
    logic         load_ready;
    logic         serial_out;
    logic         busy;
    logic         rx_valid;
    logic [W-1:0] rx_data;

    assign serial_in = loop_en ? serial_out : ser_drv;

    spi_shift_engine #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_data     (load_data),
        .sample_strobe (sample_strobe),
        .shift_strobe  (shift_strobe),
        .abort         (abort),
        .serial_in     (serial_in),
        .serial_out    (serial_out),
        .busy          (busy),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data)
`ifdef SPI_SHIFT_LSB_FIRST_EN
        ,
        .lsb_first     (lsb_first)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: phase 0 idle, 1 shifting, 2 done
    int unsigned  m_phase;
    int unsigned  m_n;
    logic [W-1:0] m_tx;
    logic [W-1:0] m_acc;
    logic [W-1:0] m_rx_data;
    logic         m_rx_valid;
    logic         m_samp;
    logic         m_lsb;
    logic         m_in;
    logic         m_b;

    // Expected shifter contents: untransmitted part of the loaded word plus received bits
    function automatic logic exp_sout();
        logic [W-1:0] s;
        if (m_lsb) s = (m_tx >> m_n) | (m_acc << (W - m_n));
        else       s = (m_tx << m_n) | m_acc;
        return m_lsb ? s[0] : s[W-1];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_n = 0; m_tx = '0; m_acc = '0; m_rx_data = '0;
            m_rx_valid = 1'b0; m_samp = 1'b0; m_lsb = 1'b0;
        end else begin
            m_in = loop_en ? exp_sout() : ser_drv;
            m_rx_valid = 1'b0;
            if (abort) begin
                m_phase = 0; m_n = 0; m_tx = '0; m_acc = '0;
            end else if (m_phase == 0) begin
                if (load_valid) begin
                    m_tx = load_data; m_acc = '0; m_n = 0; m_phase = 1;
`ifdef SPI_SHIFT_LSB_FIRST_EN
                    m_lsb = lsb_first;
`endif
                end
            end else if (m_phase == 1) begin
                m_b = sample_strobe ? m_in : m_samp;
                if (sample_strobe) m_samp = m_in;
                if (shift_strobe) begin
                    if (m_lsb) m_acc[m_n] = m_b;
                    else       m_acc = {m_acc[W-2:0], m_b};
                    m_n++;
                    if (m_n == W) begin
                        m_phase = 2; m_rx_data = m_acc; m_rx_valid = 1'b1;
                    end
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", busy, (m_phase != 0));
            check("load_ready", load_ready, (m_phase == 0));
            check("rx_valid", rx_valid, m_rx_valid);
            check("rx_data", rx_data, m_rx_data);
            check("serial_out", serial_out, exp_sout());
        end
    end

    task automatic load(input logic [W-1:0] d);
        load_valid = 1'b1; load_data = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic pair_sep();
        sample_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0; shift_strobe = 1'b1;
        @(negedge clk);
        shift_strobe = 1'b0;
    endtask

    task automatic pair_byp();
        sample_strobe = 1'b1; shift_strobe = 1'b1;
        @(negedge clk);
        sample_strobe = 1'b0; shift_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pat;
        rst_n = 1'b0; load_valid = 1'b0; load_data = '0; sample_strobe = 1'b0;
        shift_strobe = 1'b0; abort = 1'b0; ser_drv = 1'b0; loop_en = 1'b0; lsb_first = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset load_ready", load_ready, 1);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_data", rx_data, 0);
        check("reset serial_out", serial_out, 0);
        rst_n = 1'b1; cmp_en = 1'b1;
        @(negedge clk);

        // 0xA5 loopback, separate sample then shift
        loop_en = 1'b1; pat = 8'hA5;
        load(8'hA5);
        for (int i = 0; i < 8; i++) begin
            check("A5 serial_out bit", serial_out, pat[7-i]);
            pair_sep();
        end
        check("A5 rx_valid", rx_valid, 1);
        check("A5 rx_data", rx_data, 8'hA5);
        @(negedge clk);
        check("A5 idle busy", busy, 0);
        check("A5 rx_valid pulse", rx_valid, 0);

        // Bypass path: sample and shift in the same cycle, serial_in held high
        loop_en = 1'b0; ser_drv = 1'b1;
        load(8'h00);
        repeat (8) pair_byp();
        check("bypass rx_data", rx_data, 8'hFF);
        @(negedge clk);
        check("bypass busy after done", busy, 0);

        // load_valid held through a word: new data waits until IDLE
        loop_en = 1'b1;
        load_valid = 1'b1; load_data = 8'hC3;
        @(negedge clk);
        load_data = 8'h3C;
        repeat (8) pair_byp();
        check("held rx_data", rx_data, 8'hC3);
        check("held load_ready in done", load_ready, 0);
        @(negedge clk);
        check("held load_ready idle", load_ready, 1);
        @(negedge clk);
        load_valid = 1'b0;
        check("held second accepted", busy, 1);
        check("held second msb", serial_out, 0);

        // Abort after three shifts
        repeat (3) pair_byp();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort load_ready", load_ready, 1);
        check("abort rx_valid", rx_valid, 0);
        check("abort rx_data kept", rx_data, 8'hC3);

        // Abort in the same cycle as a load accept
        load_valid = 1'b1; load_data = 8'hFF; abort = 1'b1;
        @(negedge clk);
        load_valid = 1'b0; abort = 1'b0;
        check("abort beats load", busy, 0);

        // Irregular strobes, including shifts that reuse a stale sample
        loop_en = 1'b0;
        load(8'h96);
        for (int k = 0; k < 300; k++) begin
            if (rx_valid) break;
            sample_strobe = 1'($urandom_range(0, 1));
            shift_strobe  = ($urandom_range(0, 2) == 0);
            ser_drv       = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        sample_strobe = 1'b0; shift_strobe = 1'b0;
        check("random word completed", rx_valid, 1);
        @(negedge clk);

        // Asynchronous reset mid-word, then a clean word
        ser_drv = 1'b0;
        load(8'h77);
        repeat (2) pair_byp();
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst load_ready", load_ready, 1);
        check("async rst rx_data", rx_data, 0);
        check("async rst serial_out", serial_out, 0);
        check("async rst rx_valid", rx_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loop_en = 1'b1;
        load(8'h5A);
        repeat (8) pair_sep();
        check("5A rx_valid", rx_valid, 1);
        check("5A rx_data", rx_data, 8'h5A);
        @(negedge clk);

`ifdef SPI_SHIFT_LSB_FIRST_EN
        // LSB-first loopback of 0x01
        lsb_first = 1'b1;
        load(8'h01);
        lsb_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("lsb serial_out bit", serial_out, (i == 0));
            pair_sep();
        end
        check("lsb rx_data", rx_data, 8'h01);
        @(negedge clk);
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
